timer_cmp_irq: RTL and testbench
================================

# timer_cmp_irq

Compare/interrupt stage sitting directly downstream of the free-running timer peripheral. It consumes the timer's 32-bit count, compares it against a software-programmed deadline, and raises a level interrupt to the core. In periodic mode it advances the deadline by a programmed period. It is an Avalon-MM-style slave on the same peripheral bus as the timer.

## Interface
- DATA_W, 32, bus and count width
- MCNT_W, 8, width of saturating match counter
- clock  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- address  in  2  register select
- writedata  in  32  write data
- write  in  1  write strobe, qualified by chipselect
- read  in  1  read strobe, qualified by chipselect
- chipselect  in  1  slave select
- readdata  out  32  read data, combinational
- waitrequest  out  1  tied 0
- count_in  in  32  timer count (timer register 1), sampled every cycle
- irq  out  1  interrupt request, level, active-high

## Operation
- Registers, all reset to 0:
  - 0 CTRL: bit0 EN, bit1 PERIODIC, bit2 IE; other bits read 0.
  - 1 CMP: deadline.
  - 2 PERIOD: reload increment.
  - 3 STATUS: bit0 PEND, bit1 OVR, bits[8+MCNT_W-1:8] MATCH_CNT. Writing 1 to bit0/bit1 clears it; writing bit31=1 clears MATCH_CNT. Other bits ignored.
- Match condition: diff = count_in - CMP (mod 2^32); match when diff[31]==0. Wrap-safe: a deadline up to 2^31-1 ahead is treated as future.
- FSM states:
  - IDLE: EN=0.
  - ARMED: EN=1, waiting.
  - FIRED: one-shot expired.
- Transitions:
  - IDLE->ARMED when EN written 1.
  - Any state->IDLE when EN written 0.
  - ARMED with match:
    - PEND<=1; if PEND was already 1, OVR<=1.
    - MATCH_CNT increments, saturating at 2^MCNT_W-1.
    - If PERIODIC=1 and PERIOD!=0: CMP<=CMP+PERIOD (wrap mod 2^32), stay ARMED.
    - Otherwise go to FIRED.
  - FIRED->ARMED on any write to CMP while EN=1.
- irq = PEND & IE, driven only from flops.
- readdata = (read & chipselect) ? selected register : 0.
- Simultaneous events:
  - STATUS W1C of PEND in the same cycle as a new match: match wins, PEND stays 1, OVR is not set.
  - Write to CMP or PERIOD in the same cycle as a match: the write wins, CMP takes writedata, and the match is discarded for that cycle.
  - Write EN=0 in the same cycle as a match: go to IDLE, match ignored.
- Reset mid-operation clears all registers and returns to IDLE. irq is 0 on the cycle after the reset edge.

## Timing
- Match evaluated on count_in and CMP at posedge N. PEND, CMP reload, state and irq update at edge N, visible in cycle N+1.
- Register write at edge N; the new value takes part in compare from cycle N+1.
- Read has zero wait states. Read data is combinational from the current register state.
- The periodic reload is a single-cycle add with no bubble. Back-to-back matches are possible when PERIOD is smaller than the timer step rate.

## Structure
- Shared package timer_cmp_pkg:
  - Register address constants: CTRL=0, CMP=1, PERIOD=2, STATUS=3.
  - CTRL and STATUS bit indices.
  - FSM state enum: IDLE, ARMED, FIRED.
- No sub-module. The comparator and the reload adder are inline. Estimated size is about 150-200 lines.

## Test plan
- Reset check: drive resetn=0 for 2 cycles with count_in=5. Expect all registers to read 0, irq=0, state IDLE.
- One-shot: CMP=100, CTRL=0b101, count_in ramps 90..110. Expect PEND=1 and irq=1 in the cycle after count_in=100, state FIRED, MATCH_CNT=1, no further increments. W1C STATUS=1 must drop irq the next cycle.
- Periodic with overrun: CMP=10, PERIOD=5, CTRL=0b111, count_in increments each cycle, PEND never cleared. Expect CMP to read 15, 20, 25..., OVR=1 after the 2nd match, MATCH_CNT saturating at 255.
- Wrap: CMP=0x0000_0004, count_in goes 0xFFFF_FFF0 -> 0x0000_0010. Expect no match before count_in=4, then a match at 4.
- Collision: issue the PEND W1C on the exact match cycle and expect PEND=1 afterwards. Write CMP=500 on a match cycle and expect no PEND and CMP=500.
- Re-arm and disable:
  - In FIRED, write CMP=count_in+3 and expect a match 3 cycles later.
  - Write EN=0 while ARMED with a pending match and expect IDLE with no new PEND.

Source files
------------

// File: rtl/timer_cmp_pkg.sv
// Shared constants for the timer compare/interrupt stage: register map,
// CTRL/STATUS bit positions and the compare FSM state encoding.
package timer_cmp_pkg;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_CMP    = 2'd1;
   localparam logic [1:0] ADDR_PERIOD = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_PERIODIC = 1;
   localparam int CTRL_IE       = 2;

   localparam int STS_PEND     = 0;
   localparam int STS_OVR      = 1;
   localparam int STS_MCNT_LSB = 8;
   localparam int STS_MCNT_CLR = 31;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_FIRED = 2'd2
   } cmp_state_e;

endpackage

// File: rtl/timer_cmp_irq.sv
// Compares the free-running timer count against a programmable deadline and
// raises a level interrupt; periodic mode advances the deadline in place.
module timer_cmp_irq
   import timer_cmp_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int MCNT_W = 8
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic [1:0]        address,
   input  logic [DATA_W-1:0] writedata,
   input  logic              write,
   input  logic              read,
   input  logic              chipselect,
   output logic [DATA_W-1:0] readdata,
   output logic              waitrequest,
   input  logic [DATA_W-1:0] count_in,
   output logic              irq
);

   localparam logic [MCNT_W-1:0] MCNT_MAX = {MCNT_W{1'b1}};
   localparam logic [MCNT_W-1:0] MCNT_ONE = {{(MCNT_W-1){1'b0}}, 1'b1};

   cmp_state_e        r_state, w_state_nxt;
   logic              r_en, r_per, r_ie, r_pend, r_ovr, r_irq;
   logic [DATA_W-1:0] r_cmp, r_period;
   logic [MCNT_W-1:0] r_mcnt;

   logic              w_wr, w_wr_ctrl, w_wr_cmp, w_wr_period, w_wr_status;
   logic              w_en_off, w_hit, w_reload, w_pend_clr;
   logic              w_en_nxt, w_per_nxt, w_ie_nxt, w_pend_nxt, w_ovr_nxt;
   logic [DATA_W-1:0] w_diff, w_cmp_nxt, w_period_nxt, w_ctrl, w_status, w_rsel;
   logic [MCNT_W-1:0] w_mcnt_base, w_mcnt_nxt;

   assign w_wr        = write & chipselect;
   assign w_wr_ctrl   = w_wr & (address == ADDR_CTRL);
   assign w_wr_cmp    = w_wr & (address == ADDR_CMP);
   assign w_wr_period = w_wr & (address == ADDR_PERIOD);
   assign w_wr_status = w_wr & (address == ADDR_STATUS);
   assign w_en_off    = w_wr_ctrl & ~writedata[CTRL_EN];

   // Wrap-safe compare: the deadline is reached once count - cmp is non-negative.
   assign w_diff = count_in - r_cmp;
   assign w_hit  = (r_state == ST_ARMED) & ~w_diff[DATA_W-1]
                 & ~w_wr_cmp & ~w_wr_period & ~w_en_off;
   assign w_reload   = w_hit & r_per & (r_period != {DATA_W{1'b0}});
   assign w_pend_clr = w_wr_status & writedata[STS_PEND];

   // Next values of all architectural registers, including the FSM.
   always_comb begin
      w_state_nxt  = r_state;
      w_en_nxt     = w_wr_ctrl ? writedata[CTRL_EN]       : r_en;
      w_per_nxt    = w_wr_ctrl ? writedata[CTRL_PERIODIC] : r_per;
      w_ie_nxt     = w_wr_ctrl ? writedata[CTRL_IE]       : r_ie;
      w_period_nxt = w_wr_period ? writedata : r_period;
      w_cmp_nxt    = w_wr_cmp ? writedata : (w_reload ? r_cmp + r_period : r_cmp);
      w_pend_nxt   = w_hit | (r_pend & ~w_pend_clr);
      w_ovr_nxt    = (w_hit & r_pend & ~w_pend_clr)
                   | (r_ovr & ~(w_wr_status & writedata[STS_OVR]));
      w_mcnt_base  = (w_wr_status & writedata[STS_MCNT_CLR]) ? {MCNT_W{1'b0}} : r_mcnt;
      w_mcnt_nxt   = (w_hit && (w_mcnt_base != MCNT_MAX)) ? w_mcnt_base + MCNT_ONE
                                                          : w_mcnt_base;
      case (r_state)
         ST_IDLE: begin
            if (w_wr_ctrl & writedata[CTRL_EN]) w_state_nxt = ST_ARMED;
            else                                w_state_nxt = ST_IDLE;
         end
         ST_ARMED: begin
            if (w_en_off)                w_state_nxt = ST_IDLE;
            else if (w_hit & ~w_reload)  w_state_nxt = ST_FIRED;
            else                         w_state_nxt = ST_ARMED;
         end
         ST_FIRED: begin
            if (w_en_off)             w_state_nxt = ST_IDLE;
            else if (w_wr_cmp & r_en) w_state_nxt = ST_ARMED;
            else                      w_state_nxt = ST_FIRED;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Register state update with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state  <= ST_IDLE;
         r_en     <= 1'b0;
         r_per    <= 1'b0;
         r_ie     <= 1'b0;
         r_cmp    <= {DATA_W{1'b0}};
         r_period <= {DATA_W{1'b0}};
         r_pend   <= 1'b0;
         r_ovr    <= 1'b0;
         r_mcnt   <= {MCNT_W{1'b0}};
         r_irq    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_en     <= w_en_nxt;
         r_per    <= w_per_nxt;
         r_ie     <= w_ie_nxt;
         r_cmp    <= w_cmp_nxt;
         r_period <= w_period_nxt;
         r_pend   <= w_pend_nxt;
         r_ovr    <= w_ovr_nxt;
         r_mcnt   <= w_mcnt_nxt;
         r_irq    <= w_pend_nxt & w_ie_nxt;
      end
   end

   // Register read mux; unused bits read as zero.
   always_comb begin
      w_ctrl                          = {DATA_W{1'b0}};
      w_ctrl[CTRL_EN]                 = r_en;
      w_ctrl[CTRL_PERIODIC]           = r_per;
      w_ctrl[CTRL_IE]                 = r_ie;
      w_status                        = {DATA_W{1'b0}};
      w_status[STS_PEND]              = r_pend;
      w_status[STS_OVR]               = r_ovr;
      w_status[STS_MCNT_LSB +: MCNT_W] = r_mcnt;
      case (address)
         ADDR_CTRL:   w_rsel = w_ctrl;
         ADDR_CMP:    w_rsel = r_cmp;
         ADDR_PERIOD: w_rsel = r_period;
         ADDR_STATUS: w_rsel = w_status;
         default:     w_rsel = {DATA_W{1'b0}};
      endcase
   end

   assign readdata    = (read & chipselect) ? w_rsel : {DATA_W{1'b0}};
   assign waitrequest = 1'b0;
   assign irq         = r_irq;

endmodule

// File: tb/tb_timer_cmp_irq.sv
// Directed self-checking bench for timer_cmp_irq: reset, one-shot, periodic
// with overrun/saturation, wrap, collisions, re-arm and disable.
`timescale 1ns/1ps
module tb_timer_cmp_irq;

   logic        clock;
   logic        resetn;
   logic [1:0]  address;
   logic [31:0] writedata;
   logic        write;
   logic        read;
   logic        chipselect;
   logic [31:0] readdata;
   logic        waitrequest;
   logic [31:0] count_in;
   logic        irq;

   int checks;
   int failures;

   timer_cmp_irq #(.DATA_W(32), .MCNT_W(8)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .address     (address),
      .writedata   (writedata),
      .write       (write),
      .read        (read),
      .chipselect  (chipselect),
      .readdata    (readdata),
      .waitrequest (waitrequest),
      .count_in    (count_in),
      .irq         (irq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; write = 1'b1; chipselect = 1'b1;
      tick();
      write = 1'b0; chipselect = 1'b0; writedata = 32'd0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      address = a; read = 1'b1; chipselect = 1'b1;
      #1;
      d = readdata;
      read = 1'b0; chipselect = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      count_in = 32'd5;
      do_reset();
      for (int a = 0; a < 4; a++) begin
         bus_read(a[1:0], d);
         checks++;
         if (d !== 32'd0) begin
            failures++;
            $display("FAIL reset_reg%0d got=%h exp=%h", a, d, 32'd0);
         end
      end
      checks++;
      if (irq !== 1'b0 || waitrequest !== 1'b0) begin
         failures++;
         $display("FAIL reset_irq_wait got=%b%b exp=00", irq, waitrequest);
      end
      // CMP=0 and count=5 would match if armed; IDLE must ignore it.
      repeat (3) tick();
      bus_read(2'd3, d);
      checks++;
      if (d !== 32'd0 || irq !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle got=%h irq=%b exp=%h irq=0", d, irq, 32'd0);
      end
   endtask

   task automatic test_oneshot();
      logic [31:0] d;
      logic        exp_irq;
      count_in = 32'd90;
      bus_write(2'd1, 32'd100);
      bus_write(2'd0, 32'h5);
      for (int c = 90; c <= 110; c++) begin
         count_in = c;
         tick();
         exp_irq = (c >= 100);
         checks++;
         if (irq !== exp_irq) begin
            failures++;
            $display("FAIL oneshot_irq count=%0d got=%b exp=%b", c, irq, exp_irq);
         end
      end
      bus_read(2'd3, d);
      checks++;
      if (d !== 32'h0000_0101) begin
         failures++;
         $display("FAIL oneshot_status got=%h exp=%h", d, 32'h0000_0101);
      end
      bus_read(2'd1, d);
      checks++;
      if (d !== 32'd100) begin
         failures++;
         $display("FAIL oneshot_cmp got=%h exp=%h", d, 32'd100);
      end
      bus_write(2'd3, 32'h1);
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL oneshot_w1c_irq got=%b exp=0", irq);
      end
      bus_read(2'd3, d);
      checks++;
      if (d !== 32'h0000_0100) begin
         failures++;
         $display("FAIL oneshot_w1c_status got=%h exp=%h", d, 32'h0000_0100);
      end
   endtask

   task automatic test_periodic();
      logic [31:0] d;
      do_reset();
      bus_read(2'd3, d);
      checks++;
      if (d !== 32'd0 || irq !== 1'b0) begin
         failures++;
         $display("FAIL midreset_status got=%h irq=%b exp=0 irq=0", d, irq);
      end
      count_in = 32'd0;
      bus_write(2'd1, 32'd10);
      bus_write(2'd2, 32'd5);
      bus_write(2'd0, 32'h7);
      for (int c = 10; c <= 1510; c++) begin
         count_in = c;
         tick();
         if (c == 10) begin
            bus_read(2'd1, d);
            checks++;
            if (d !== 32'd15) begin
               failures++;
               $display("FAIL periodic_cmp1 got=%0d exp=15", d);
            end
            bus_read(2'd3, d);
            checks++;
            if (d !== 32'h0000_0101) begin
               failures++;
               $display("FAIL periodic_status1 got=%h exp=%h", d, 32'h0000_0101);
            end
         end else if (c == 15) begin
            bus_read(2'd1, d);
            checks++;
            if (d !== 32'd20) begin
               failures++;
               $display("FAIL periodic_cmp2 got=%0d exp=20", d);
            end
            bus_read(2'd3, d);
            checks++;
            if (d !== 32'h0000_0203) begin
               failures++;
               $display("FAIL periodic_ovr got=%h exp=%h", d, 32'h0000_0203);
            end
         end else if (c == 20) begin
            bus_read(2'd1, d);
            checks++;
            if (d !== 32'd25) begin
               failures++;
               $display("FAIL periodic_cmp3 got=%0d exp=25", d);
            end
         end
      end
      bus_read(2'd1, d);
      checks++;
      if (d !== 32'd1515) begin
         failures++;
         $display("FAIL periodic_cmp_end got=%0d exp=1515", d);
      end
      bus_read(2'd3, d);
      checks++;
      if (d !== 32'h0000_FF03 || irq !== 1'b1) begin
         failures++;
         $display("FAIL periodic_sat got=%h irq=%b exp=%h irq=1", d, irq, 32'h0000_FF03);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] d;
      logic [31:0] c;
      logic        wrapped;
      logic        exp_irq;
      do_reset();
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL wrap_reset_irq got=%b exp=0", irq);
      end
      count_in = 32'hFFFF_FFF0;
      bus_write(2'd1, 32'h0000_0004);
      bus_write(2'd0, 32'h5);
      c = 32'hFFFF_FFF0;
      wrapped = 1'b0;
      for (int k = 0; k < 33; k++) begin
         count_in = c;
         tick();
         exp_irq = wrapped && (c >= 32'd4);
         checks++;
         if (irq !== exp_irq) begin
            failures++;
            $display("FAIL wrap_irq count=%h got=%b exp=%b", c, irq, exp_irq);
         end
         c = c + 32'd1;
         if (c == 32'd0) wrapped = 1'b1;
      end
      bus_read(2'd3, d);
      checks++;
      if (d !== 32'h0000_0101) begin
         failures++;
         $display("FAIL wrap_status got=%h exp=%h", d, 32'h0000_0101);
      end
   endtask

   task automatic test_collision();
      logic [31:0] d;
      do_reset();
      count_in = 32'd0;
      bus_write(2'd1, 32'd50);
      bus_write(2'd2, 32'd10);
      bus_write(2'd0, 32'h7);
      count_in = 32'd50;
      tick();
      count_in = 32'd60;
      bus_write(2'd3, 32'h1);
      bus_read(2'd3, d);
      checks++;
      if (d !== 32'h0000_0201) begin
         failures++;
         $display("FAIL collide_w1c got=%h exp=%h", d, 32'h0000_0201);
      end
      bus_read(2'd1, d);
      checks++;
      if (d !== 32'd70) begin
         failures++;
         $display("FAIL collide_w1c_cmp got=%0d exp=70", d);
      end
      count_in = 32'd61;
      bus_write(2'd3, 32'h8000_0003);
      bus_read(2'd3, d);
      checks++;
      if (d !== 32'd0) begin
         failures++;
         $display("FAIL collide_clear_all got=%h exp=%h", d, 32'd0);
      end
      count_in = 32'd70;
      bus_write(2'd1, 32'd500);
      bus_read(2'd3, d);
      checks++;
      if (d !== 32'd0 || irq !== 1'b0) begin
         failures++;
         $display("FAIL collide_cmp_status got=%h irq=%b exp=0 irq=0", d, irq);
      end
      bus_read(2'd1, d);
      checks++;
      if (d !== 32'd500) begin
         failures++;
         $display("FAIL collide_cmp_value got=%0d exp=500", d);
      end
   endtask

   task automatic test_rearm_disable();
      logic [31:0] d;
      logic        exp_irq;
      do_reset();
      count_in = 32'd0;
      bus_write(2'd1, 32'd20);
      bus_write(2'd0, 32'h5);
      count_in = 32'd20;
      tick();
      checks++;
      if (irq !== 1'b1) begin
         failures++;
         $display("FAIL rearm_first_irq got=%b exp=1", irq);
      end
      bus_write(2'd3, 32'h1);
      count_in = 32'd25;
      tick();
      bus_read(2'd3, d);
      checks++;
      if (d !== 32'h0000_0100 || irq !== 1'b0) begin
         failures++;
         $display("FAIL rearm_fired_hold got=%h irq=%b exp=%h irq=0", d, irq, 32'h0000_0100);
      end
      bus_write(2'd1, 32'd28);
      for (int k = 1; k <= 3; k++) begin
         count_in = 32'd25 + k;
         tick();
         exp_irq = (k == 3);
         checks++;
         if (irq !== exp_irq) begin
            failures++;
            $display("FAIL rearm_irq step=%0d got=%b exp=%b", k, irq, exp_irq);
         end
      end
      bus_read(2'd3, d);
      checks++;
      if (d !== 32'h0000_0201) begin
         failures++;
         $display("FAIL rearm_status got=%h exp=%h", d, 32'h0000_0201);
      end
      bus_write(2'd3, 32'h1);
      bus_write(2'd1, 32'd40);
      count_in = 32'd40;
      bus_write(2'd0, 32'h4);
      bus_read(2'd3, d);
      checks++;
      if (d !== 32'h0000_0200 || irq !== 1'b0) begin
         failures++;
         $display("FAIL disable_status got=%h irq=%b exp=%h irq=0", d, irq, 32'h0000_0200);
      end
      count_in = 32'd41;
      tick();
      bus_read(2'd3, d);
      checks++;
      if (d !== 32'h0000_0200) begin
         failures++;
         $display("FAIL disable_idle got=%h exp=%h", d, 32'h0000_0200);
      end
      bus_read(2'd0, d);
      checks++;
      if (d !== 32'h4) begin
         failures++;
         $display("FAIL disable_ctrl got=%h exp=%h", d, 32'h4);
      end
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      resetn     = 1'b0;
      address    = 2'd0;
      writedata  = 32'd0;
      write      = 1'b0;
      read       = 1'b0;
      chipselect = 1'b0;
      count_in   = 32'd0;
      test_reset();
      test_oneshot();
      test_periodic();
      test_wrap();
      test_collision();
      test_rearm_disable();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
